// File: rtl/e155_fp_pkg.sv
// Shared constants and types for the SPI frame receiver.
// Imported by the receiver top level.
package e155_fp_pkg;

    localparam int DEFAULT_FRAME_BITS = 48;
    localparam int SD_BITS            = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Generic N-flop synchronizer for a single asynchronous bit.
// Reset drives every stage to RST_VAL so no false edge follows reset.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: oversamples sck/sdi/cs_n on int_osc,
// checks the bit count and presents each good frame with a valid pulse.
module spi_frame_rx
    import e155_fp_pkg::*;
#(
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  int_osc,
    input  logic                  reset_n,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs_n,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_valid,
    output logic                  frame_new,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    logic sck_s;
    logic sdi_s;
    logic cs_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk   (int_osc),
        .rst_n (reset_n),
        .d     (sck),
        .q     (sck_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk   (int_osc),
        .rst_n (reset_n),
        .d     (sdi),
        .q     (sdi_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (int_osc),
        .rst_n (reset_n),
        .d     (cs_n),
        .q     (cs_s)
    );

    rx_state_t             state_q,       state_d;
    logic                  sck_prev_q,    sck_prev_d;
    logic                  cs_prev_q,     cs_prev_d;
    logic                  sck_rise_q,    sck_rise_d;
    logic                  cs_rise_q,     cs_rise_d;
    logic                  cs_fall_q,     cs_fall_d;
    logic [FRAME_BITS-1:0] shreg_q,       shreg_d;
    logic [CW-1:0]         bitcnt_q,      bitcnt_d;
    logic [FRAME_BITS-1:0] frame_q,       frame_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_new_q,   frame_new_d;
    logic                  frame_err_q,   frame_err_d;
    logic                  busy_q,        busy_d;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        frame_new_d   = 1'b0;
        frame_err_d   = 1'b0;
        sck_prev_d    = sck_s;
        cs_prev_d     = cs_s;
        sck_rise_d    = sck_s & ~sck_prev_q;
        cs_rise_d     = cs_s & ~cs_prev_q;
        // A select fall seen while CHECK is busy waits for IDLE.
        cs_fall_d     = (~cs_s & cs_prev_q)
                      | (cs_fall_q & (state_q == CHECK));

        unique case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d  = SHIFT;
                    shreg_d  = '0;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (cs_rise_q) begin
                    state_d = CHECK;
                end else if (sck_rise_q) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_s};
                    if (bitcnt_q != CNT_SAT) begin
                        bitcnt_d = bitcnt_q + CW'(1);
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (bitcnt_q == CNT_FULL) begin
                    frame_d       = shreg_q;
                    frame_valid_d = 1'b1;
                    frame_new_d   = (shreg_q != frame_q);
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sck_prev_q    <= 1'b0;
            cs_prev_q     <= 1'b1;
            sck_rise_q    <= 1'b0;
            cs_rise_q     <= 1'b0;
            cs_fall_q     <= 1'b0;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_new_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sck_prev_q    <= sck_prev_d;
            cs_prev_q     <= cs_prev_d;
            sck_rise_q    <= sck_rise_d;
            cs_rise_q     <= cs_rise_d;
            cs_fall_q     <= cs_fall_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_new_q   <= frame_new_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign frame_new   = frame_new_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: transaction-level model of expected pulses,
// frame and busy window, compared every cycle, plus literal pins.
module tb_spi_frame_rx;

    localparam int FB  = 48;
    localparam int BIG = 32'h7fff_ffff;

    logic          int_osc = 1'b0;
    logic          reset_n;
    logic          sck;
    logic          sdi;
    logic          cs_n;
    logic [FB-1:0] frame;
    logic          frame_valid;
    logic          frame_new;
    logic          frame_err;
    logic          busy;

    spi_frame_rx dut (
        .int_osc     (int_osc),
        .reset_n     (reset_n),
        .sck         (sck),
        .sdi         (sdi),
        .cs_n        (cs_n),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_new   (frame_new),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #21 int_osc = ~int_osc;

    typedef struct {
        int            cyc;
        bit            ok;
        bit            isnew;
        logic [FB-1:0] fr;
    } ev_t;

    ev_t           evq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            chk_en = 0;
    int            busy_on = BIG;
    int            busy_off = BIG;
    logic [FB-1:0] model_last = '0;
    logic [FB-1:0] exp_frame = '0;
    int            n_valid = 0;
    int            n_new = 0;
    int            n_err = 0;
    int            first_valid_cyc = -1;
    int            first_rise_cyc = -1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h",
                     nm, cyc, act, exp);
        end
    endtask

    // Every cycle: outputs must equal what the transaction model predicts.
    always begin
        logic ev_v, ev_n, ev_e, exp_b;
        @(posedge int_osc);
        cyc++;
        #1;
        if (chk_en) begin
            ev_v = 1'b0;
            ev_n = 1'b0;
            ev_e = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev_v = evq[0].ok;
                ev_n = evq[0].isnew;
                ev_e = !evq[0].ok;
                if (evq[0].ok) exp_frame = evq[0].fr;
                void'(evq.pop_front());
            end
            exp_b = (cyc >= busy_on) && (cyc < busy_off);
            chk("cycle",
                {frame_valid, frame_new, frame_err, busy, frame},
                {ev_v, ev_n, ev_e, exp_b, exp_frame});
            n_valid += int'(frame_valid);
            n_new   += int'(frame_new);
            n_err   += int'(frame_err);
            if (frame_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge int_osc);
    endtask

    // 2 MHz sck: 6 int_osc cycles per phase, MSB first.
    task automatic send(input logic [63:0] d, input int n, input bit close);
        ev_t e;
        @(negedge int_osc);
        cs_n     = 1'b0;
        busy_on  = cyc + 4;
        busy_off = BIG;
        tick(6);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = d[i];
            tick(6);
            sck = 1'b1;
            tick(6);
            sck = 1'b0;
        end
        if (close) begin
            tick(6);
            cs_n     = 1'b1;
            busy_off = cyc + 4;
            if (first_rise_cyc < 0) first_rise_cyc = cyc;
            e.cyc   = cyc + 5;
            e.ok    = (n == FB);
            e.fr    = d[FB-1:0];
            e.isnew = e.ok && (d[FB-1:0] != model_last);
            if (e.ok) model_last = d[FB-1:0];
            evq.push_back(e);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        sck     = 1'b0;
        sdi     = 1'b0;
        cs_n    = 1'b1;
        tick(3);
        chk("reset_outputs",
            {frame_valid, frame_new, frame_err, busy, frame}, 64'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(5);

        send(64'h3C05_470A_5203, 48, 1'b1);
        tick(12);
        chk("f1_frame", frame, 64'h3C05_470A_5203);
        chk("f1_counts", {n_valid, n_new, n_err}, {32'd1, 32'd1, 32'd0});
        chk("f1_latency", first_valid_cyc - first_rise_cyc, 64'd5);

        send(64'h3C05_470A_5203, 48, 1'b1);
        tick(12);
        chk("f1_repeat", {n_valid, n_new, n_err}, {32'd2, 32'd1, 32'd0});

        send(64'h1234_5678_9ABC, 47, 1'b1);
        tick(12);
        send(64'h1_FEDC_BA98_7654, 49, 1'b1);
        tick(12);
        chk("bad_counts", {n_valid, n_new, n_err}, {32'd2, 32'd1, 32'd2});
        chk("bad_frame_held", frame, 64'h3C05_470A_5203);

        for (int i = 0; i < 10; i++) begin
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(4);
        end
        chk("idle_sck", {n_valid, n_new, n_err}, {32'd2, 32'd1, 32'd2});
        send(64'hFFFF_0000_AAAA, 48, 1'b1);
        tick(12);
        chk("f2_frame", frame, 64'hFFFF_0000_AAAA);
        chk("f2_counts", {n_valid, n_new, n_err}, {32'd3, 32'd2, 32'd2});

        send(64'hDEAD_BEEF_CAFE, 20, 1'b0);
        @(negedge int_osc);
        reset_n    = 1'b0;
        chk_en     = 1'b0;
        evq.delete();
        cs_n       = 1'b1;
        sck        = 1'b0;
        sdi        = 1'b0;
        busy_on    = BIG;
        busy_off   = BIG;
        model_last = '0;
        exp_frame  = '0;
        tick(2);
        chk("mid_reset",
            {frame_valid, frame_new, frame_err, busy, frame}, 64'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(5);
        send(64'h0000_0000_0001, 48, 1'b1);
        tick(12);
        chk("f3_frame", frame, 64'h1);
        chk("f3_counts", {n_valid, n_new, n_err}, {32'd4, 32'd3, 32'd2});

        send(64'hA5A5_5A5A_0F0F, 48, 1'b1);
        tick(3);
        send(64'hA5A5_5A5A_0F0F, 48, 1'b1);
        tick(12);
        chk("b2b_frame", frame, 64'hA5A5_5A5A_0F0F);
        chk("b2b_counts", {n_valid, n_new, n_err}, {32'd6, 32'd4, 32'd2});

        tick(10);
        chk("events_drained", evq.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
